// File: rtl/reg_transfer_pkg.sv
// Shared types, opcode/ALU constants and opcode-class helpers for the
// register-transfer sequencer and its step decoder.
package reg_transfer_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    DECODE = 3'd1,
    T0     = 3'd2,
    T1     = 3'd3,
    T2     = 3'd4
  } state_e;

  localparam logic [4:0] OP_ADD  = 5'b00000;
  localparam logic [4:0] OP_SUB  = 5'b00001;
  localparam logic [4:0] OP_AND  = 5'b00010;
  localparam logic [4:0] OP_OR   = 5'b00011;
  localparam logic [4:0] OP_ADDI = 5'b01000;
  localparam logic [4:0] OP_ANDI = 5'b01001;
  localparam logic [4:0] OP_ORI  = 5'b01010;

  localparam logic [3:0] ALU_ADD = 4'b0000;
  localparam logic [3:0] ALU_SUB = 4'b0001;
  localparam logic [3:0] ALU_AND = 4'b0010;
  localparam logic [3:0] ALU_OR  = 4'b0011;

  typedef struct packed {
    logic       busy;
    logic       done;
    logic       illegal;
    logic       gra;
    logic       grb;
    logic       grc;
    logic       rin;
    logic       rout;
    logic       baout;
    logic       yin;
    logic       zin;
    logic       zlowout;
    logic       cout;
    logic [3:0] alu_func;
  } ctrl_t;

  function automatic logic is_alu_r(input logic [4:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR: return 1'b1;
      default:                       return 1'b0;
    endcase
  endfunction

  function automatic logic is_alu_i(input logic [4:0] op);
    case (op)
      OP_ADDI, OP_ANDI, OP_ORI: return 1'b1;
      default:                  return 1'b0;
    endcase
  endfunction

  function automatic logic [3:0] alu_func_of(input logic [4:0] op);
    case (op)
      OP_SUB:         return ALU_SUB;
      OP_AND, OP_ANDI: return ALU_AND;
      OP_OR,  OP_ORI:  return ALU_OR;
      default:        return ALU_ADD;
    endcase
  endfunction

endpackage

// File: rtl/reg_transfer_sequencer_step_decoder.sv
// Combinational map from sequencer state and latched opcode to the
// register-select / datapath strobe bundle.
module step_decoder
  import reg_transfer_pkg::*;
(
  input  state_e     state_i,
  input  logic       is_r_i,
  input  logic       is_i_i,
  input  logic [4:0] opcode_i,
  output ctrl_t      ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (state_i)
      DECODE: begin
        ctrl_o.busy    = 1'b1;
        ctrl_o.illegal = ~(is_r_i | is_i_i);
      end
      T0: begin
        ctrl_o.busy = 1'b1;
        ctrl_o.grb  = 1'b1;
        ctrl_o.rout = 1'b1;
        ctrl_o.yin  = 1'b1;
      end
      T1: begin
        ctrl_o.busy     = 1'b1;
        ctrl_o.zin      = 1'b1;
        ctrl_o.alu_func = alu_func_of(opcode_i);
        // Second operand: immediate C for I-type, register Rc for R-type.
        if (is_i_i) begin
          ctrl_o.cout = 1'b1;
        end else if (is_r_i) begin
          ctrl_o.grc  = 1'b1;
          ctrl_o.rout = 1'b1;
        end
      end
      T2: begin
        ctrl_o.busy    = 1'b1;
        ctrl_o.zlowout = 1'b1;
        ctrl_o.gra     = 1'b1;
        ctrl_o.rin     = 1'b1;
        ctrl_o.done    = 1'b1;
      end
      default: ctrl_o = '0;
    endcase
  end

endmodule

// File: rtl/reg_transfer_sequencer.sv
// Moore control-step sequencer: latches an ALU instruction on start and
// walks it through DECODE, T0, T1, T2 driving the register-select strobes.
module reg_transfer_sequencer
  import reg_transfer_pkg::*;
#(
  parameter int unsigned ALU_OP_W = 4
) (
  input  logic                clk,
  input  logic                clr,
  input  logic                start,
  input  logic                stall,
  input  logic [31:0]         ir_in,
  output logic                busy,
  output logic                done,
  output logic                illegal,
  output logic                Gra,
  output logic                Grb,
  output logic                Grc,
  output logic                Rin,
  output logic                Rout,
  output logic                BAout,
  output logic                Yin,
  output logic                Zin,
  output logic                Zlowout,
  output logic                Cout,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic [31:0]         ir_latched
);

  state_e      state_q, state_d;
  logic [31:0] ir_q, ir_d;
  logic [4:0]  opcode;
  logic        cls_r, cls_i;
  ctrl_t       ctrl;

  assign opcode = ir_q[31:27];
  assign cls_r  = is_alu_r(opcode);
  assign cls_i  = is_alu_i(opcode);

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          ir_d    = ir_in;
          state_d = DECODE;
        end
      end
      DECODE: if (!stall) state_d = (cls_r || cls_i) ? T0 : IDLE;
      T0:     if (!stall) state_d = T1;
      T1:     if (!stall) state_d = T2;
      T2:     if (!stall) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= IDLE;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  step_decoder u_step_decoder (
    .state_i  (state_q),
    .is_r_i   (cls_r),
    .is_i_i   (cls_i),
    .opcode_i (opcode),
    .ctrl_o   (ctrl)
  );

  assign busy       = ctrl.busy;
  assign done       = ctrl.done;
  assign illegal    = ctrl.illegal;
  assign Gra        = ctrl.gra;
  assign Grb        = ctrl.grb;
  assign Grc        = ctrl.grc;
  assign Rin        = ctrl.rin;
  assign Rout       = ctrl.rout;
  assign BAout      = ctrl.baout;
  assign Yin        = ctrl.yin;
  assign Zin        = ctrl.zin;
  assign Zlowout    = ctrl.zlowout;
  assign Cout       = ctrl.cout;
  assign alu_op     = ALU_OP_W'(ctrl.alu_func);
  assign ir_latched = ir_q;

endmodule

// File: tb/tb_reg_transfer_sequencer.sv
// Scoreboard bench for reg_transfer_sequencer: stimulus pushes the expected
// per-cycle output vector, a negedge monitor pops and compares.
module tb_reg_transfer_sequencer;

  typedef struct packed {
    logic        busy;
    logic        done;
    logic        illegal;
    logic        gra;
    logic        grb;
    logic        grc;
    logic        rin;
    logic        rout;
    logic        baout;
    logic        yin;
    logic        zin;
    logic        zlowout;
    logic        cout;
    logic [3:0]  alu_op;
    logic [31:0] irl;
  } obs_t;

  localparam logic [31:0] I_ADD  = 32'h0188_8000;
  localparam logic [31:0] I_ORI  = 32'h5128_001F;
  localparam logic [31:0] I_SUB  = 32'h0890_8000;
  localparam logic [31:0] I_AND  = 32'h1000_0000;
  localparam logic [31:0] I_OR   = 32'h1800_0000;
  localparam logic [31:0] I_ADDI = 32'h4000_0000;
  localparam logic [31:0] I_ANDI = 32'h4800_0000;
  localparam logic [31:0] I_BAD  = 32'hF800_0000;

  logic        clk = 1'b0;
  logic        clr, start, stall;
  logic [31:0] ir_in;
  logic        busy, done, illegal, Gra, Grb, Grc, Rin, Rout, BAout;
  logic        Yin, Zin, Zlowout, Cout;
  logic [3:0]  alu_op;
  logic [31:0] ir_latched;

  obs_t  exp_q[$];
  string tag_q[$];
  int    checks = 0;
  int    errors = 0;
  obs_t  mon_e, mon_a;
  string mon_t;

  always #5 clk = ~clk;

  reg_transfer_sequencer #(.ALU_OP_W(4)) dut (
    .clk(clk), .clr(clr), .start(start), .stall(stall), .ir_in(ir_in),
    .busy(busy), .done(done), .illegal(illegal),
    .Gra(Gra), .Grb(Grb), .Grc(Grc), .Rin(Rin), .Rout(Rout), .BAout(BAout),
    .Yin(Yin), .Zin(Zin), .Zlowout(Zlowout), .Cout(Cout),
    .alu_op(alu_op), .ir_latched(ir_latched)
  );

  function automatic obs_t e_idle(input logic [31:0] irl);
    obs_t o = '0;
    o.irl = irl;
    return o;
  endfunction

  function automatic obs_t e_dec(input logic [31:0] irl);
    obs_t o = e_idle(irl);
    o.busy = 1'b1;
    return o;
  endfunction

  function automatic obs_t e_ill(input logic [31:0] irl);
    obs_t o = e_dec(irl);
    o.illegal = 1'b1;
    return o;
  endfunction

  function automatic obs_t e_t0(input logic [31:0] irl);
    obs_t o = e_dec(irl);
    o.grb = 1'b1; o.rout = 1'b1; o.yin = 1'b1;
    return o;
  endfunction

  function automatic obs_t e_t1r(input logic [31:0] irl, input logic [3:0] f);
    obs_t o = e_dec(irl);
    o.grc = 1'b1; o.rout = 1'b1; o.zin = 1'b1; o.alu_op = f;
    return o;
  endfunction

  function automatic obs_t e_t1i(input logic [31:0] irl, input logic [3:0] f);
    obs_t o = e_dec(irl);
    o.cout = 1'b1; o.zin = 1'b1; o.alu_op = f;
    return o;
  endfunction

  function automatic obs_t e_t2(input logic [31:0] irl);
    obs_t o = e_dec(irl);
    o.zlowout = 1'b1; o.gra = 1'b1; o.rin = 1'b1; o.done = 1'b1;
    return o;
  endfunction

  // Drive one cycle of inputs and queue the outputs expected in this cycle.
  task automatic cyc(input logic s, input logic stl, input logic c,
                     input logic [31:0] ir, input obs_t e, input string tag);
    start = s;
    stall = stl;
    clr   = c;
    ir_in = ir;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_t = tag_q.pop_front();
      mon_a = {busy, done, illegal, Gra, Grb, Grc, Rin, Rout, BAout,
               Yin, Zin, Zlowout, Cout, alu_op, ir_latched};
      checks++;
      if (mon_a !== mon_e) begin
        errors++;
        $display("FAIL %s: got %h expected %h", mon_t, mon_a, mon_e);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    clr = 1'b1; start = 1'b0; stall = 1'b0; ir_in = '0;
    repeat (2) @(posedge clk);
    #1;
    cyc(0, 0, 1, '0, e_idle('0), "reset_idle");

    // abort mid-T1
    cyc(1, 0, 0, I_ADD, e_idle('0),      "abort_start");
    cyc(0, 0, 0, '0,    e_dec(I_ADD),    "abort_dec");
    cyc(0, 0, 0, '0,    e_t0(I_ADD),     "abort_t0");
    cyc(0, 0, 1, '0,    e_t1r(I_ADD, 4'b0000), "abort_t1");
    cyc(0, 0, 0, '0,    e_idle('0),      "abort_after");
    cyc(0, 0, 0, '0,    e_idle('0),      "abort_no_done");

    // ADD r3,r1,r2
    cyc(1, 0, 0, I_ADD, e_idle('0),      "add_start");
    cyc(0, 0, 0, '0,    e_dec(I_ADD),    "add_dec");
    cyc(0, 0, 0, '0,    e_t0(I_ADD),     "add_t0");
    cyc(0, 0, 0, '0,    e_t1r(I_ADD, 4'b0000), "add_t1");
    cyc(0, 0, 0, '0,    e_t2(I_ADD),     "add_t2");
    cyc(0, 0, 0, '0,    e_idle(I_ADD),   "add_idle");

    // ORI r2,r5,0x1F
    cyc(1, 0, 0, I_ORI, e_idle(I_ADD),   "ori_start");
    cyc(0, 0, 0, '0,    e_dec(I_ORI),    "ori_dec");
    cyc(0, 0, 0, '0,    e_t0(I_ORI),     "ori_t0");
    cyc(0, 0, 0, '0,    e_t1i(I_ORI, 4'b0011), "ori_t1");
    cyc(0, 0, 0, '0,    e_t2(I_ORI),     "ori_t2");
    cyc(0, 0, 0, '0,    e_idle(I_ORI),   "ori_idle");

    // unsupported opcode 11111
    cyc(1, 0, 0, I_BAD, e_idle(I_ORI),   "bad_start");
    cyc(0, 0, 0, '0,    e_ill(I_BAD),    "bad_dec");
    cyc(0, 0, 0, '0,    e_idle(I_BAD),   "bad_idle");

    // SUB with a 3-cycle stall in T1
    cyc(1, 0, 0, I_SUB, e_idle(I_BAD),   "sub_start");
    cyc(0, 0, 0, '0,    e_dec(I_SUB),    "sub_dec");
    cyc(0, 0, 0, '0,    e_t0(I_SUB),     "sub_t0");
    cyc(0, 1, 0, '0,    e_t1r(I_SUB, 4'b0001), "sub_t1_a");
    cyc(0, 1, 0, '0,    e_t1r(I_SUB, 4'b0001), "sub_t1_b");
    cyc(0, 1, 0, '0,    e_t1r(I_SUB, 4'b0001), "sub_t1_c");
    cyc(0, 0, 0, '0,    e_t1r(I_SUB, 4'b0001), "sub_t1_d");
    cyc(0, 0, 0, '0,    e_t2(I_SUB),     "sub_t2");
    cyc(0, 0, 0, '0,    e_idle(I_SUB),   "sub_idle");

    // start held high, ir_in changing every cycle
    cyc(1, 0, 0, I_AND,  e_idle(I_SUB),  "b2b_start0");
    cyc(1, 0, 0, I_OR,   e_dec(I_AND),   "b2b_dec0");
    cyc(1, 0, 0, I_BAD,  e_t0(I_AND),    "b2b_t0_0");
    cyc(1, 0, 0, I_SUB,  e_t1r(I_AND, 4'b0010), "b2b_t1_0");
    cyc(1, 0, 0, I_SUB,  e_t2(I_AND),    "b2b_t2_0");
    cyc(1, 0, 0, I_ADDI, e_idle(I_AND),  "b2b_start1");
    cyc(1, 0, 0, I_OR,   e_dec(I_ADDI),  "b2b_dec1");
    cyc(1, 0, 0, I_BAD,  e_t0(I_ADDI),   "b2b_t0_1");
    cyc(1, 0, 0, I_SUB,  e_t1i(I_ADDI, 4'b0000), "b2b_t1_1");
    cyc(0, 0, 0, I_SUB,  e_t2(I_ADDI),   "b2b_t2_1");
    cyc(0, 0, 0, '0,     e_idle(I_ADDI), "b2b_idle");

    // start accepted with stall in IDLE
    cyc(1, 1, 0, I_ANDI, e_idle(I_ADDI), "andi_start_stall");
    cyc(0, 0, 0, '0,     e_dec(I_ANDI),  "andi_dec");
    cyc(0, 0, 0, '0,     e_t0(I_ANDI),   "andi_t0");
    cyc(0, 0, 0, '0,     e_t1i(I_ANDI, 4'b0010), "andi_t1");
    cyc(0, 0, 0, '0,     e_t2(I_ANDI),   "andi_t2");
    cyc(0, 0, 0, '0,     e_idle(I_ANDI), "andi_idle");

    // illegal re-asserted while stalled in DECODE
    cyc(1, 0, 0, I_BAD, e_idle(I_ANDI),  "bad2_start");
    cyc(0, 1, 0, '0,    e_ill(I_BAD),    "bad2_dec_stall");
    cyc(0, 0, 0, '0,    e_ill(I_BAD),    "bad2_dec");
    cyc(0, 0, 0, '0,    e_idle(I_BAD),   "bad2_idle");

    // done re-asserted while stalled in T2
    cyc(1, 0, 0, I_OR, e_idle(I_BAD),    "or_start");
    cyc(0, 0, 0, '0,   e_dec(I_OR),      "or_dec");
    cyc(0, 0, 0, '0,   e_t0(I_OR),       "or_t0");
    cyc(0, 0, 0, '0,   e_t1r(I_OR, 4'b0011), "or_t1");
    cyc(0, 1, 0, '0,   e_t2(I_OR),       "or_t2_stall");
    cyc(0, 0, 0, '0,   e_t2(I_OR),       "or_t2");
    cyc(0, 0, 0, '0,   e_idle(I_OR),     "or_idle");

    #10;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/reg_transfer_sequencer.md
Name: reg_transfer_sequencer

Overview:
- Control-step sequencer that drives the register select/encode interface (Gra, Grb, Grc, Rin, Rout, BAout) plus the Y/Z/C-path strobes needed to run one ALU instruction through the shared bus.
- Sits between the instruction register and the register-select logic, which it drives directly.
- Latches the instruction at start, steps it through a fixed three-step Moore sequence, and signals completion.

Parameters:
- ALU_OP_W, 4, width of the alu_op output.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- clr  in  1  synchronous active-high reset.
- start  in  1  request to execute ir_in; sampled only in IDLE.
- stall  in  1  freeze the current step; outputs hold.
- ir_in  in  32  instruction word; opcode in ir_in[31:27].
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse on the final step.
- illegal  out  1  one-cycle pulse when a latched opcode is unsupported.
- Gra, Grb, Grc  out  1 each  register-field selects.
- Rin, Rout, BAout  out  1 each  register write, register drive and base-address drive.
- Yin, Zin, Zlowout, Cout  out  1 each  Y load, Z load, Z-low drive and sign-extended-C drive.
- alu_op  out  ALU_OP_W  ALU function code; valid only while Zin is high.
- ir_latched  out  32  held copy of the instruction, for the select/encode block.

Behaviour:
- Reset: clr=1 at a clock edge forces IDLE and ir_latched=0. All outputs are 0 during the following cycle.
- clr overrides start and stall, and aborts any sequence in progress. No done pulse follows an abort.
- Outputs are a pure function of state and ir_latched (Moore); there is no input-to-output combinational path.
- States: IDLE, DECODE, T0, T1, T2.
- IDLE + start=1: ir_latched<=ir_in, go to DECODE. start in any other state is ignored.
- DECODE, opcode in ALU_R set (ADD 00000, SUB 00001, AND 00010, OR 00011): go to T0.
- DECODE, opcode in ALU_I set (ADDI 01000, ANDI 01001, ORI 01010): go to T0.
- DECODE, any other opcode: illegal=1 for this cycle, go to IDLE.
- R-type steps:
  - T0: Grb, Rout, Yin.
  - T1: Grc, Rout, Zin, alu_op=op code.
  - T2: Zlowout, Gra, Rin, done.
- I-type steps:
  - T0: Grb, Rout, Yin.
  - T1: Cout, Zin, alu_op=op code.
  - T2: Zlowout, Gra, Rin, done.
- alu_op mapping: ADD/ADDI=0000, SUB=0001, AND/ANDI=0010, OR/ORI=0011. alu_op=0 whenever Zin=0.
- Rout and BAout are never asserted together. At most one of Gra/Grb/Grc is high in any cycle.
- Latency: start to done = 4 cycles (DECODE, T0, T1, T2) with no stall. The cycle after T2 is IDLE, so a new start can be accepted there: back-to-back issue every 5 cycles.
- stall=1 in DECODE or T0–T2: state holds and outputs repeat unchanged. done and illegal are re-asserted each stalled cycle in which they would be high.
- stall in IDLE has no effect. start with stall=1 in IDLE is still accepted.
- ir_in changes after acceptance have no effect until the next accepted start.

Decomposition:
- Shared package reg_transfer_pkg holds:
  - state typedef (IDLE, DECODE, T0, T1, T2);
  - 5-bit opcode constants;
  - ALU function-code constants;
  - opcode-class function is_alu_r / is_alu_i.
- One sub-module: step_decoder, a combinational map from (state, opcode class, opcode) to the control-line bundle. The sequencer keeps only the state register and ir_latched.

Test Plan:
- Reset: clr=1 mid-T1 -> next cycle busy=0, all controls 0, ir_latched=0, no done pulse.
- ADD r3,r1,r2 (ir_in=0x01888000), start 1 cycle:
  - cycle+2: Grb, Rout, Yin;
  - cycle+3: Grc, Rout, Zin, alu_op=0000;
  - cycle+4: Zlowout, Gra, Rin, done=1;
  - cycle+5: busy=0.
- ORI r2,r5,0x1F (opcode 01010) -> T1 shows Cout, Zin, alu_op=0011 with Grc=0.
- Opcode 11111 -> illegal pulses in DECODE cycle, back to IDLE, no Rin ever asserted.
- stall=1 for 3 cycles during T1 of SUB -> Zin/Grc/Rout/alu_op=0001 held 4 cycles; done arrives 3 cycles late.
- start held high continuously with changing ir_in -> only the IDLE-cycle value executes; issues every 5 cycles; ir_latched is stable during each sequence.
